// File: rtl/board_input_conditioner_pkg.sv
// Shared constants for the board input conditioner: raw idle levels and debounce sizing.
package board_input_conditioner_pkg;

  localparam logic KEY_IDLE_RAW = 1'b1;
  localparam logic SW_IDLE_RAW  = 1'b0;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

  // Counter width that can count to the given number of cycles with one bit of headroom.
  function automatic int unsigned cnt_width_for(input int unsigned cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/board_input_conditioner_debounce_bit.sv
// One conditioned input bit: 2-flop synchronizer, stability counter and accepted-level register.
module debounce_bit
  import board_input_conditioner_pkg::*;
#(
  parameter logic        IDLE_VAL        = SW_IDLE_RAW,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_WIDTH       = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic change_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 s1_q, s2_q;
  logic                 stable_q, stable_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // change_o flags the edge at which stable_q takes the new level.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    change_o = 1'b0;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = s2_q;
      cnt_d    = '0;
      change_o = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= IDLE_VAL;
      s2_q     <= IDLE_VAL;
      stable_q <= IDLE_VAL;
      cnt_q    <= '0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = stable_q;

endmodule

// File: rtl/board_input_conditioner.sv
// Debounced key/switch levels plus sticky key-press events read through a clear-on-read handshake.
// Optional auto-repeat of held keys is enabled by defining KEY_AUTO_REPEAT_EN.
module board_input_conditioner
  import board_input_conditioner_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned NUM_SW          = 10,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_WIDTH       = 19,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n_in,
  input  logic [NUM_SW-1:0]   sw_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_SW-1:0]   sw_level,
  output logic                event_pending,
  input  logic                rd_req,
  output logic                rd_valid,
  output logic [NUM_KEYS-1:0] rd_events
);

  logic [NUM_KEYS-1:0] key_stable, key_change;
  logic [NUM_SW-1:0]   sw_stable, unused_sw_change;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    debounce_bit #(
      .IDLE_VAL       (KEY_IDLE_RAW),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_db (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (key_n_in[i]),
      .level_o (key_stable[i]),
      .change_o(key_change[i])
    );
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_bit #(
      .IDLE_VAL       (SW_IDLE_RAW),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_db (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (sw_in[i]),
      .level_o (sw_stable[i]),
      .change_o(unused_sw_change[i])
    );
  end

  assign key_level = ~key_stable;
  assign sw_level  = sw_stable;

  // A key accepting a change while its stable raw level is still 1 (released) is a press.
  logic [NUM_KEYS-1:0] press_set, repeat_set, event_set;
  assign press_set = key_change & key_stable;

`ifdef KEY_AUTO_REPEAT_EN
  logic [NUM_KEYS-1:0][31:0] hold_q;
  logic [NUM_KEYS-1:0]       armed_q;

  always_comb begin
    repeat_set = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (key_level[k]) begin
        if (armed_q[k]) repeat_set[k] = (hold_q[k] == REPEAT_PERIOD - 1);
        else            repeat_set[k] = (hold_q[k] == REPEAT_DELAY - 1);
      end
    end
  end

  // First repeat fires REPEAT_DELAY cycles into the hold, later ones every REPEAT_PERIOD.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (reset || !key_level[k]) begin
        hold_q[k]  <= '0;
        armed_q[k] <= 1'b0;
      end else if (repeat_set[k]) begin
        hold_q[k]  <= '0;
        armed_q[k] <= 1'b1;
      end else begin
        hold_q[k]  <= hold_q[k] + 32'd1;
      end
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign repeat_set        = '0;
`endif

  assign event_set = press_set | repeat_set;

  logic [NUM_KEYS-1:0] event_q, event_d;
  logic [NUM_KEYS-1:0] rd_events_q;
  logic                pending_q, rd_valid_q;

  // A set landing on the same edge as a read wins: it stays pending and is left out of the snapshot.
  assign event_d = (event_q & ~{NUM_KEYS{rd_req}}) | event_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      event_q     <= '0;
      pending_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_events_q <= '0;
    end else begin
      event_q    <= event_d;
      pending_q  <= |event_d;
      rd_valid_q <= rd_req;
      if (rd_req) rd_events_q <= event_q & ~event_set;
    end
  end

  assign event_pending = pending_q;
  assign rd_valid      = rd_valid_q;
  assign rd_events     = rd_events_q;

endmodule
